// File: rtl/riscv_trap_ctrl_if.sv
// Core <-> machine-mode trap controller bundle: event inputs, CSR access port
// and the PC-redirect handshake toward fetch.
interface riscv_trap_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            irq_mei;
  logic            irq_mti;
  logic            irq_msi;
  logic            ret_vld;
  logic [XLEN-1:0] ret_pc;
  logic            exc_vld;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_vld;
  logic            evt_rdy;
  logic            csr_vld;
  logic            csr_wen;
  logic [11:0]     csr_adr;
  logic [XLEN-1:0] csr_wdt;
  logic            csr_rdy;
  logic [XLEN-1:0] csr_rdt;
  logic            csr_ill;
  logic            trp_vld;
  logic [XLEN-1:0] trp_pc;
  logic            trp_rdy;

  // Controller side
  modport slave (
    input  irq_mei, irq_mti, irq_msi, ret_vld, ret_pc,
    input  exc_vld, exc_cause, exc_pc, exc_tval, mret_vld,
    input  csr_vld, csr_wen, csr_adr, csr_wdt, trp_rdy,
    output evt_rdy, csr_rdy, csr_rdt, csr_ill, trp_vld, trp_pc
  );

  // Core side
  modport master (
    output irq_mei, irq_mti, irq_msi, ret_vld, ret_pc,
    output exc_vld, exc_cause, exc_pc, exc_tval, mret_vld,
    output csr_vld, csr_wen, csr_adr, csr_wdt, trp_rdy,
    input  evt_rdy, csr_rdy, csr_rdt, csr_ill, trp_vld, trp_pc
  );
endinterface

// File: rtl/riscv_trap_ctrl.sv
// RV64 machine-mode trap controller: owns the M-mode trap CSRs, arbitrates
// exceptions / mret / interrupts and drives the fetch redirect handshake.
module riscv_trap_ctrl #(
  parameter int unsigned      XLEN      = 64,
  parameter logic [XLEN-1:0]  MTVEC_RST = 64'h0000_0000_0000_0000,
  parameter logic [XLEN-1:0]  MISA_VAL  = 64'h8000_0000_0000_1104
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  riscv_trap_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            mst_mie_q, mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic [2:0]      mie_q, mie_d;          // {MEIE, MTIE, MSIE}
  logic [2:0]      mip_q;                 // {MEIP, MTIP, MSIP}
  logic [XLEN-1:2] tvec_base_q, tvec_base_d;
  logic            tvec_mode_q, tvec_mode_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;        // bit0 is always written as 0
  logic            mcause_int_q, mcause_int_d;
  logic [3:0]      mcause_code_q, mcause_code_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            trp_vld_q, trp_vld_d;
  logic [XLEN-1:0] trp_pc_q, trp_pc_d;

  logic            idle_s;
  logic [2:0]      pend_s;
  logic [3:0]      int_code_s;
  logic            int_take_s;
  logic            csr_rdy_s;
  logic            csr_we_s;
  logic            csr_ill_s;
  logic [XLEN-1:0] csr_rdt_s;
  logic [XLEN-1:0] vec_off_s;
  logic [XLEN-1:0] tvec_pc_s;

  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  assign idle_s     = (state_q == ST_IDLE);
  assign pend_s     = mip_q & mie_q & {3{mst_mie_q}};
  assign int_take_s = idle_s & bus.ret_vld & (pend_s != 3'b000);
  assign csr_rdy_s  = idle_s & ~bus.exc_vld & ~bus.mret_vld & ~int_take_s;
  assign csr_we_s   = bus.csr_vld & csr_rdy_s & bus.csr_wen & ~csr_ill_s;
  assign vec_off_s  = {{(XLEN-6){1'b0}}, int_code_s, 2'b00};
  assign tvec_pc_s  = {tvec_base_q, 2'b00};

  // Fixed interrupt priority: external, then software, then timer
  always_comb begin
    if (pend_s[2]) begin
      int_code_s = 4'd11;
    end else if (pend_s[0]) begin
      int_code_s = 4'd3;
    end else begin
      int_code_s = 4'd7;
    end
  end

  // CSR read mux and unimplemented-address decode (pre-write values)
  always_comb begin
    csr_ill_s = 1'b0;
    csr_rdt_s = {XLEN{1'b0}};
    case (bus.csr_adr)
      12'h300: csr_rdt_s = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mst_mpie_q,
                            3'b000, mst_mie_q, 3'b000};
      12'h301: csr_rdt_s = MISA_VAL;
      12'h304: csr_rdt_s = {{(XLEN-12){1'b0}}, mie_q[2], 3'b000, mie_q[1],
                            3'b000, mie_q[0], 3'b000};
      12'h305: csr_rdt_s = {tvec_base_q, 1'b0, tvec_mode_q};
      12'h340: csr_rdt_s = mscratch_q;
      12'h341: csr_rdt_s = mepc_q;
      12'h342: csr_rdt_s = {mcause_int_q, {(XLEN-5){1'b0}}, mcause_code_q};
      12'h343: csr_rdt_s = mtval_q;
      12'h344: csr_rdt_s = {{(XLEN-12){1'b0}}, mip_q[2], 3'b000, mip_q[1],
                            3'b000, mip_q[0], 3'b000};
      default: csr_ill_s = 1'b1;
    endcase
  end

  // Event arbitration, trap entry/exit sequencing and CSR writes
  always_comb begin
    state_d       = state_q;
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mie_d         = mie_q;
    tvec_base_d   = tvec_base_q;
    tvec_mode_d   = tvec_mode_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;
    mtval_d       = mtval_q;
    trp_vld_d     = trp_vld_q;
    trp_pc_d      = trp_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.exc_vld) begin
          mepc_d        = bus.exc_pc & PC_ALIGN_MASK;
          mcause_int_d  = 1'b0;
          mcause_code_d = bus.exc_cause;
          mtval_d       = bus.exc_tval;
          mst_mpie_d    = mst_mie_q;
          mst_mie_d     = 1'b0;
          trp_vld_d     = 1'b1;
          trp_pc_d      = tvec_pc_s;
          state_d       = ST_TRAP;
        end else if (bus.mret_vld) begin
          mst_mie_d     = mst_mpie_q;
          mst_mpie_d    = 1'b1;
          trp_vld_d     = 1'b1;
          trp_pc_d      = mepc_q;
          state_d       = ST_RET;
        end else if (int_take_s) begin
          mepc_d        = bus.ret_pc & PC_ALIGN_MASK;
          mcause_int_d  = 1'b1;
          mcause_code_d = int_code_s;
          mtval_d       = {XLEN{1'b0}};
          mst_mpie_d    = mst_mie_q;
          mst_mie_d     = 1'b0;
          trp_vld_d     = 1'b1;
          // Wraps modulo 2^XLEN by construction
          trp_pc_d      = tvec_mode_q ? (tvec_pc_s + vec_off_s) : tvec_pc_s;
          state_d       = ST_TRAP;
        end else if (csr_we_s) begin
          case (bus.csr_adr)
            12'h300: begin
              mst_mie_d  = bus.csr_wdt[3];
              mst_mpie_d = bus.csr_wdt[7];
            end
            12'h304: mie_d = {bus.csr_wdt[11], bus.csr_wdt[7], bus.csr_wdt[3]};
            12'h305: begin
              tvec_base_d = bus.csr_wdt[XLEN-1:2];
              // Reserved MODE encodings leave the previous MODE in place
              if (bus.csr_wdt[1]) begin
                tvec_mode_d = tvec_mode_q;
              end else begin
                tvec_mode_d = bus.csr_wdt[0];
              end
            end
            12'h340: mscratch_d = bus.csr_wdt;
            12'h341: mepc_d     = bus.csr_wdt & PC_ALIGN_MASK;
            12'h342: begin
              mcause_int_d  = bus.csr_wdt[XLEN-1];
              mcause_code_d = bus.csr_wdt[3:0];
            end
            12'h343: mtval_d    = bus.csr_wdt;
            default: ;  // misa and mip ignore writes
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP, ST_RET: begin
        if (bus.trp_rdy) begin
          trp_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          trp_vld_d = 1'b1;
        end
      end
      default: begin
        trp_vld_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State, CSR and redirect registers; async reset abandons any open trap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_q         <= 3'b000;
      mip_q         <= 3'b000;
      tvec_base_q   <= MTVEC_RST[XLEN-1:2];
      tvec_mode_q   <= MTVEC_RST[0];
      mscratch_q    <= {XLEN{1'b0}};
      mepc_q        <= {XLEN{1'b0}};
      mcause_int_q  <= 1'b0;
      mcause_code_q <= 4'd0;
      mtval_q       <= {XLEN{1'b0}};
      trp_vld_q     <= 1'b0;
      trp_pc_q      <= {XLEN{1'b0}};
    end else begin
      state_q       <= state_d;
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mie_q         <= mie_d;
      mip_q         <= {bus.irq_mei, bus.irq_mti, bus.irq_msi};
      tvec_base_q   <= tvec_base_d;
      tvec_mode_q   <= tvec_mode_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_int_q  <= mcause_int_d;
      mcause_code_q <= mcause_code_d;
      mtval_q       <= mtval_d;
      trp_vld_q     <= trp_vld_d;
      trp_pc_q      <= trp_pc_d;
    end
  end

  assign bus.evt_rdy = idle_s;
  assign bus.csr_rdy = csr_rdy_s;
  assign bus.csr_rdt = csr_rdt_s;
  assign bus.csr_ill = csr_ill_s;
  assign bus.trp_vld = trp_vld_q;
  assign bus.trp_pc  = trp_pc_q;

endmodule

// File: doc/riscv_trap_ctrl.md
Name: riscv_trap_ctrl

Overview:
- Machine-mode trap controller for the RV64 M-mode CSR set: mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval and mip.
- Owns those CSRs and serves the core's CSR access port.
- Arbitrates exceptions, mret and the three M-level interrupts, and sequences trap entry and exit.
- Drives a PC-redirect handshake to the core fetch stage.

Parameters:
XLEN, 64, register width
MTVEC_RST, 64'h0000_0000_0000_0000, mtvec reset value (BASE and MODE)
MISA_VAL, 64'h8000_0000_0000_1104, read-only misa value (MXL=2, I, M, C)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
irq_mei  in  1  machine external interrupt, level
irq_mti  in  1  machine timer interrupt, level
irq_msi  in  1  machine software interrupt, level
ret_vld  in  1  instruction boundary: interrupt may be taken
ret_pc  in  XLEN  PC of next instruction at boundary
exc_vld  in  1  synchronous exception request
exc_cause  in  4  exception code
exc_pc  in  XLEN  faulting PC
exc_tval  in  XLEN  trap value
mret_vld  in  1  mret request
evt_rdy  out  1  controller accepts exc/mret/interrupt (state IDLE)
csr_vld  in  1  CSR access request
csr_wen  in  1  CSR write enable
csr_adr  in  12  CSR address
csr_wdt  in  XLEN  CSR write data (final value, RMW done by core)
csr_rdy  out  1  CSR access accepted this cycle
csr_rdt  out  XLEN  CSR read data, combinational, pre-write value
csr_ill  out  1  unimplemented address, combinational
trp_vld  out  1  redirect valid
trp_pc  out  XLEN  redirect target
trp_rdy  in  1  core accepts redirect

Behaviour:
- Reset (rst low, async):
  - state=IDLE, mstatus.MIE=0, MPIE=0, MPP=2'b11.
  - mie=0, mip=0, mtvec=MTVEC_RST.
  - mscratch, mepc, mcause, mtval = 0.
  - trp_vld=0, trp_pc=0.
  - Reset mid-trap aborts the sequence with no partial CSR update.
- CSR field rules:
  - mstatus: only MIE(3), MPIE(7), MPP(12:11) exist. MPP is WARL fixed 2'b11. All other bits read 0.
  - misa: reads MISA_VAL. Writes ignored.
  - mie: MEIE(11), MTIE(7), MSIE(3) writable. Other bits read 0.
  - mip: MEIP/MTIP/MSIP are the irq inputs registered 1 cycle. Read-only; writes ignored.
  - mtvec: BASE[XLEN-1:2] writable. MODE bit0 writable, bit1 reads 0. A write with csr_wdt[1:0]>=2 keeps the old MODE and still updates BASE.
  - mepc: bit0 reads 0 (IALIGN=16).
  - mcause: bit XLEN-1 and [3:0] writable. Other bits read 0.
  - mtval, mscratch: full width.
- CSR access:
  - Implemented addresses: 0x300, 0x301, 0x304, 0x305, 0x340, 0x341, 0x342, 0x343, 0x344.
  - Any other address: csr_ill=1, csr_rdt=0, no write.
  - csr_rdy = IDLE & !exc_vld & !mret_vld & !int_take.
  - A write is committed on the edge where csr_vld & csr_rdy & csr_wen & !csr_ill, and is visible the next cycle.
- Interrupt selection:
  - pend = mip & mie, gated by mstatus.MIE.
  - Fixed priority MEI(11) > MSI(3) > MTI(7).
  - int_take = IDLE & ret_vld & (pend != 0).
- IDLE priority: exc_vld > mret_vld > int_take > CSR access. Only one event is accepted per cycle.
- Trap entry, accepted in cycle N:
  - On edge N→N+1:
    - mepc = exc_pc (exception) or ret_pc (interrupt), with bit0 cleared.
    - mcause = {0, exc_cause} for an exception, or {1, code} for an interrupt.
    - mtval = exc_tval for an exception, or 0 for an interrupt.
    - MPIE = MIE, MIE = 0, MPP = 2'b11.
    - state = TRAP.
  - In TRAP: trp_vld=1. trp_pc = {BASE,2'b00}, or {BASE,2'b00} + 4*code when MODE=1 and the trap is an interrupt.
- mret, accepted in cycle N:
  - On edge N→N+1: MIE = MPIE, MPIE = 1, MPP = 2'b11, state = RET.
  - In RET: trp_vld=1, trp_pc = mepc.
- Redirect handshake:
  - In TRAP or RET, trp_vld and trp_pc stay stable until trp_rdy=1.
  - The state returns to IDLE on the edge where trp_vld & trp_rdy. trp_vld is 0 in the next cycle.
  - Minimum redirect latency is 1 cycle after acceptance. Back-to-back events need at least 2 cycles.
- Outside IDLE: evt_rdy=0 and csr_rdy=0. exc_vld and mret_vld must be held by the core. irq inputs keep updating mip.
- Arithmetic: vector offset is computed modulo 2^XLEN. Wrap-around is allowed and not flagged.

Test Plan:
- Reset then read 0x300 → 64'h1800; read 0x305 → MTVEC_RST; read 0x7C0 → csr_ill=1, rdt=0.
- Set mtvec=0x8000_0001, mie=0x800, mstatus=0x8, irq_mei=1, then ret_vld with ret_pc=0x1234 → next cycle trp_vld, trp_pc=0x8000_002C, mepc=0x1234, mcause=0x8000_0000_0000_000B, mstatus=0x1880.
- exc_vld(cause=2, pc=0x100, tval=0xDEAD) in the same cycle as int_take and a CSR write → exception wins: mcause=2, mtval=0xDEAD, trp_pc=BASE, CSR write dropped (csr_rdy=0).
- Hold trp_rdy=0 for 5 cycles in TRAP → trp_vld/trp_pc stable and evt_rdy=0; trp_rdy=1 → IDLE next cycle.
- mret with mstatus=0x1880, mepc=0x1234 → trp_pc=0x1234, then mstatus=0x1888.
- Write mtvec=0x4003 while MODE=1 → reads back 0x4001; write mepc=0x77 → reads 0x76; assert rst low in TRAP → trp_vld=0 immediately.
